// File: rtl/mux_arbiter_2to1.sv
// Two-requester arbiter feeding a single registered output beat.
// Round-robin on ties, bursts capped at BURST beats, with full-throughput back-pressure handling.
module mux_arbiter_2to1 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_1,
    input  logic [WIDTH-1:0] data_1,
    output logic             ack_1,
    input  logic             req_2,
    input  logic [WIDTH-1:0] data_2,
    output logic             ack_2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             out_src
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_1 = 2'd1,
        SERVE_2 = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] burst_cnt;
    logic [7:0] burst_cnt_nxt;
    logic       last_served;      // 1: requester 1 was the last one granted
    logic       last_served_nxt;
    logic       sel_nxt;
    logic       slot_free;
    logic       ack_any;
    logic       burst_done;

    assign slot_free  = ~out_valid | out_ready;
    assign ack_any    = ack_1 | ack_2;
    assign burst_done = (burst_cnt == BURST_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            last_served <= 1'b0;
            sel         <= 1'b1;
        end else begin
            state       <= state_nxt;
            burst_cnt   <= burst_cnt_nxt;
            last_served <= last_served_nxt;
            sel         <= sel_nxt;
        end
    end

    // Next-state logic; everything holds while the output slot is stalled
    always_comb begin
        state_nxt       = state;
        burst_cnt_nxt   = burst_cnt;
        last_served_nxt = last_served;
        sel_nxt         = sel;

        if (slot_free) begin
            case (state)
                IDLE: begin
                    if (req_1 & (~req_2 | ~last_served)) begin
                        state_nxt = SERVE_1;
                    end else if (req_2) begin
                        state_nxt = SERVE_2;
                    end
                end
                SERVE_1: begin
                    if (~req_1) begin
                        state_nxt = req_2 ? SERVE_2 : IDLE;
                    end else if (burst_done) begin
                        state_nxt = req_2 ? SERVE_2 : SERVE_1;
                    end
                end
                SERVE_2: begin
                    if (~req_2) begin
                        state_nxt = req_1 ? SERVE_1 : IDLE;
                    end else if (burst_done) begin
                        state_nxt = req_1 ? SERVE_1 : SERVE_2;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if ((state_nxt != state) || (ack_any && burst_done)) begin
            burst_cnt_nxt = '0;
        end else if (ack_any) begin
            burst_cnt_nxt = burst_cnt + 8'd1;
        end

        if (state_nxt != state) begin
            if (state_nxt == SERVE_1) begin
                last_served_nxt = 1'b1;
                sel_nxt         = 1'b1;
            end else if (state_nxt == SERVE_2) begin
                last_served_nxt = 1'b0;
                sel_nxt         = 1'b0;
            end
        end
    end

    // Output logic
    always_comb begin
        ack_1 = ~rst & (state == SERVE_1) & req_1 & slot_free;
        ack_2 = ~rst & (state == SERVE_2) & req_2 & slot_free;
    end

    // Output beat register; a drain and a new ack in the same cycle keep out_valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b1;
        end else if (ack_any) begin
            out_valid <= 1'b1;
            out_data  <= ack_1 ? data_1 : data_2;
            out_src   <= ack_1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
